// File: rtl/display_scan_ctrl.sv
// Refresh/scan controller for a 4-digit multiplexed 7-segment display.
// Steps the digit select, drives active-low anodes with a per-slot guard and optional leading-zero blanking.
module display_scan_ctrl #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned GUARD_CYCLES = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       blank_lz,
    input  logic [3:0] dig1,
    input  logic [3:0] dig2,
    input  logic [3:0] dig3,
    input  logic [3:0] dig4,
    output logic [1:0] sel,
    output logic [3:0] an,
    output logic       digit_tick
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned AN_W  = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [AN_W-1:0]  AN_OFF   = {AN_W{1'b1}};

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [SEL_W-1:0] sel_nxt;
    logic [AN_W-1:0]  an_nxt;
    logic             tick_nxt;
    logic             in_guard;
    logic             lz_blank;

    // State registers; an is registered from next-state values so it never lags sel/cnt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            sel        <= 2'b00;
            an         <= AN_OFF;
            digit_tick <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            sel        <= sel_nxt;
            an         <= an_nxt;
            digit_tick <= tick_nxt;
        end
    end

    // Slot counter and digit-select advance
    always_comb begin
        cnt_nxt  = cnt;
        sel_nxt  = sel;
        tick_nxt = 1'b0;
        if (!en) begin
            cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
            cnt_nxt  = '0;
            sel_nxt  = sel + SEL_W'(1);
            tick_nxt = 1'b1;
        end else begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    // A digit is blanked when every more-significant digit, and itself, is zero
    always_comb begin
        lz_blank = 1'b0;
        if (blank_lz) begin
            case (sel_nxt)
                2'd3:    lz_blank = (dig4 == 4'd0);
                2'd2:    lz_blank = (dig4 == 4'd0) && (dig3 == 4'd0);
                2'd1:    lz_blank = (dig4 == 4'd0) && (dig3 == 4'd0) && (dig2 == 4'd0);
                default: lz_blank = 1'b0;
            endcase
        end
    end

    // Anode enable for the slot position the registers are about to hold
    always_comb begin
        in_guard = (32'(cnt_nxt) < GUARD_CYCLES);
        an_nxt   = AN_OFF;
        if (en && !in_guard && !lz_blank) begin
            an_nxt = ~(AN_W'(1) << sel_nxt);
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a slot/phase model of the scan.
module tb_display_scan_ctrl;

    localparam int unsigned DIV   = 8;
    localparam int unsigned GUARD = 2;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       blank_lz;
    logic [3:0] dig1, dig2, dig3, dig4;
    logic [1:0] sel;
    logic [3:0] an;
    logic       digit_tick;

    int errors = 0;
    int checks = 0;

    display_scan_ctrl #(.REFRESH_DIV(DIV), .GUARD_CYCLES(GUARD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .blank_lz   (blank_lz),
        .dig1       (dig1),
        .dig2       (dig2),
        .dig3       (dig3),
        .dig4       (dig4),
        .sel        (sel),
        .an         (an),
        .digit_tick (digit_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: m_slot counts completed slots since reset, m_phase is the position inside the slot
    int         m_phase = 0;
    int         m_slot  = 0;
    logic [3:0] exp_an   = 4'hF;
    logic       exp_tick = 1'b0;
    logic [1:0] exp_sel;
    logic       m_wrap;

    assign exp_sel = 2'(m_slot % 4);
    assign m_wrap  = (m_phase == int'(DIV) - 1);

    function automatic logic [3:0] model_an(int ph, int sl, logic blz,
                                            logic [3:0] d1, logic [3:0] d2,
                                            logic [3:0] d3, logic [3:0] d4);
        int s;
        int top;
        s   = sl % 4;
        top = 0;
        if (d2 != 4'd0) top = 1;
        if (d3 != 4'd0) top = 2;
        if (d4 != 4'd0) top = 3;
        if (d1 == 4'd0 && top == 0) top = 0;
        if (ph < int'(GUARD)) return 4'hF;
        if (blz && s > top) return 4'hF;
        return ~(4'b0001 << s);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase  <= 0;
            m_slot   <= 0;
            exp_an   <= 4'hF;
            exp_tick <= 1'b0;
        end else if (!en) begin
            m_phase  <= 0;
            exp_an   <= 4'hF;
            exp_tick <= 1'b0;
        end else begin
            m_phase  <= m_wrap ? 0 : m_phase + 1;
            m_slot   <= m_wrap ? m_slot + 1 : m_slot;
            exp_tick <= m_wrap;
            exp_an   <= model_an(m_wrap ? 0 : m_phase + 1, m_wrap ? m_slot + 1 : m_slot,
                                 blank_lz, dig1, dig2, dig3, dig4);
        end
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b required %b at %0t", name, act, req, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Advance to the next sample point and compare the DUT against the model
    task automatic cycle();
        @(negedge clk);
        chk("model_sel", {2'b00, sel}, {2'b00, exp_sel});
        chk("model_an", an, exp_an);
        chk("model_tick", {3'b000, digit_tick}, {3'b000, exp_tick});
    endtask

    // Hand-derived scan pattern starting from a cnt=0 sample with en=1, blank_lz=0
    task automatic check_scan(input int n, input int sel0);
        int         s;
        logic [3:0] a;
        for (int i = 0; i < n; i++) begin
            if (i > 0) cycle();
            s = (sel0 + i / 8) % 4;
            a = (i % 8 < 2) ? 4'hF : ~(4'b0001 << s);
            chk("lit_sel", {2'b00, sel}, 4'(s));
            chk("lit_an", an, a);
            chk("lit_tick", {3'b000, digit_tick}, {3'b000, (i % 8 == 0) && (i > 0)});
        end
    endtask

    task automatic wait_for(input int s, input int ph);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if ((m_slot % 4) == s && m_phase == ph) begin
                found = 1'b1;
                break;
            end
            cycle();
        end
        if (!found) begin
            errors++;
            checks++;
            $display("FAIL wait_for: slot %0d phase %0d not reached within 64 cycles", s, ph);
        end
    endtask

    int act_cnt[4];

    task automatic collect(input int n);
        for (int k = 0; k < 4; k++) act_cnt[k] = 0;
        for (int i = 0; i < n; i++) begin
            cycle();
            if (an != 4'hF) act_cnt[sel]++;
        end
    endtask

    function automatic logic [3:0] rand_digit();
        return ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    endfunction

    initial begin
        rst_n    = 1'b1;
        en       = 1'b1;
        blank_lz = 1'b0;
        dig1 = 4'd1; dig2 = 4'd2; dig3 = 4'd3; dig4 = 4'd4;
        #1 rst_n = 1'b0;

        // Reset state and basic scan
        repeat (3) cycle();
        chk("rst_sel", {2'b00, sel}, 4'd0);
        chk("rst_an", an, 4'b1111);
        chk("rst_tick", {3'b000, digit_tick}, 4'd0);
        rst_n = 1'b1;
        check_scan(40, 0);

        // Leading-zero blanking: 0,0,5,7 and all zero
        blank_lz = 1'b1;
        dig4 = 4'd0; dig3 = 4'd0; dig2 = 4'd5; dig1 = 4'd7;
        repeat (8) cycle();
        collect(32);
        chk_int("lz_0057_s0", act_cnt[0], 6);
        chk_int("lz_0057_s1", act_cnt[1], 6);
        chk_int("lz_0057_s2", act_cnt[2], 0);
        chk_int("lz_0057_s3", act_cnt[3], 0);
        dig2 = 4'd0; dig1 = 4'd0;
        repeat (8) cycle();
        collect(32);
        chk_int("lz_0000_s0", act_cnt[0], 6);
        chk_int("lz_0000_s1", act_cnt[1], 0);
        chk_int("lz_0000_s2", act_cnt[2], 0);
        chk_int("lz_0000_s3", act_cnt[3], 0);

        // en dropped at cnt=5 of sel=2, then re-raised
        blank_lz = 1'b0;
        dig1 = 4'd1; dig2 = 4'd2; dig3 = 4'd3; dig4 = 4'd4;
        cycle();
        wait_for(2, 5);
        chk("pre_en_an", an, 4'b1011);
        en = 1'b0;
        repeat (3) begin
            cycle();
            chk("en0_an", an, 4'b1111);
            chk("en0_sel", {2'b00, sel}, 4'd2);
            chk("en0_tick", {3'b000, digit_tick}, 4'd0);
        end
        en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            chk("reen_an", an, (k < 2 || k == 8) ? 4'b1111 : 4'b1011);
            chk("reen_sel", {2'b00, sel}, (k == 8) ? 4'd3 : 4'd2);
            chk("reen_tick", {3'b000, digit_tick}, (k == 8) ? 4'd1 : 4'd0);
        end

        // Asynchronous reset mid-slot
        wait_for(3, 4);
        chk("pre_rst_an", an, 4'b0111);
        #2 rst_n = 1'b0;
        #1;
        chk("async_sel", {2'b00, sel}, 4'd0);
        chk("async_an", an, 4'b1111);
        chk("async_tick", {3'b000, digit_tick}, 4'd0);
        cycle();
        cycle();
        rst_n = 1'b1;
        check_scan(12, 0);

        // dig4 changes mid-slot while blanked
        blank_lz = 1'b1;
        dig4 = 4'd0; dig3 = 4'd1; dig2 = 4'd2; dig1 = 4'd3;
        cycle();
        wait_for(3, 3);
        chk("lz_pre_an", an, 4'b1111);
        dig4 = 4'd9;
        cycle();
        chk("lz_post_an", an, 4'b0111);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            cycle();
            if (!rst_n) begin
                rst_n = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                #3 rst_n = 1'b0;
            end
            en = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 15) == 0) blank_lz = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 11) == 0) dig1 = rand_digit();
            if ($urandom_range(0, 11) == 0) dig2 = rand_digit();
            if ($urandom_range(0, 11) == 0) dig3 = rand_digit();
            if ($urandom_range(0, 11) == 0) dig4 = rand_digit();
        end
        rst_n = 1'b1;
        repeat (4) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Refresh/scan controller for the 4-digit multiplexed 7-segment display.
- Drives the 2-bit digit-select bus into the 4:1 digit mux, plus the matching active-low anode enables.
- Inserts a per-slot guard (anodes off) against ghosting and optionally blanks leading zeros.
- Sits directly upstream of the digit mux, beside the segment decoder.

Parameters:
- REFRESH_DIV, 100000, clock cycles per digit slot (1 kHz per digit at 100 MHz); must be >= 2.
- GUARD_CYCLES, 256, cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  scan enable; 0 freezes the scan and blanks the display.
- blank_lz  in  1  1 = suppress leading zeros.
- dig1  in  4  least-significant digit value (sel=0, an[0]).
- dig2  in  4  digit value for sel=1, an[1].
- dig3  in  4  digit value for sel=2, an[2].
- dig4  in  4  most-significant digit value (sel=3, an[3]).
- sel  out  2  digit select to the mux; 00 selects dig1 … 11 selects dig4.
- an  out  4  anode enables, active-low, registered.
- digit_tick  out  1  one-cycle pulse on each slot advance.

Behaviour:
- Reset (async assert, sync release): cnt=0, sel=2'b00, an=4'b1111, digit_tick=0.
- Internal counter cnt has width clog2(REFRESH_DIV) and counts 0..REFRESH_DIV-1 while en=1.
- Terminal count (cnt==REFRESH_DIV-1, en=1). On the next edge:
  - cnt<=0.
  - sel<=sel+1, wrapping 3->0.
  - digit_tick<=1 for exactly that one cycle.
- All other cycles: digit_tick=0.
- an is a register that always reflects the same-cycle cnt/sel; it is computed from next-state values, so there is no one-cycle skew and no glitch.
- an=4'b1111 when any of these holds:
  - en=0;
  - cnt<GUARD_CYCLES;
  - the current digit is blanked.
- Otherwise an=~(4'b0001<<sel), i.e. exactly one low bit.
- Leading-zero blanking applies only when blank_lz=1:
  - sel=3 blanked iff dig4==0.
  - sel=2 blanked iff dig4==0 and dig3==0.
  - sel=1 blanked iff dig4, dig3 and dig2 are all 0.
  - sel=0 is never blanked, so value 0000 shows a single "0".
- Digit inputs are sampled every cycle; a mid-slot change affects an on the next edge.
- en=0: cnt is cleared to 0, sel holds its value, an=1111, digit_tick=0.
- en 0->1: a fresh slot starts at cnt=0 for the held sel, including the full guard period.
- Slot timing: sel is stable for exactly REFRESH_DIV cycles. The anode is active for REFRESH_DIV-GUARD_CYCLES cycles per slot. Full frame = 4*REFRESH_DIV cycles.
- Reset asserted mid-slot: all outputs immediately go to their reset values, independent of clk.
- sel never takes values other than the 4 legal codes, so the mux default branch is unreachable.

Test Plan:
All scenarios use REFRESH_DIV=8, GUARD_CYCLES=2 unless stated.
1. Reset then en=1, blank_lz=0, digits 1,2,3,4:
   - sel steps 0,1,2,3,0 every 8 cycles; digit_tick pulses once per 8 cycles.
   - an=1111 for 2 cycles, then 1110 for 6 cycles (sel=0), then 1111 x2 / 1101 x6, and so on.
2. blank_lz=1, dig4..dig1 = 0,0,5,7:
   - an stays 1111 during the sel=3 and sel=2 slots.
   - sel=1 slot shows 1101; sel=0 slot shows 1110.
3. blank_lz=1, all digits 0: only the sel=0 slot drives an=1110; every other slot stays 1111.
4. en dropped at cnt=5 with sel=2:
   - next cycle: an=1111, sel stays 2, no digit_tick.
   - en re-raised: 2 guard cycles, then an=1011 for 6 cycles, then sel=3.
5. rst_n pulsed low mid-slot (sel=3, an=0111), asynchronously between edges:
   - an=1111 and sel=00 immediately, with no clk edge.
   - after release, the scan restarts from sel=0 with a guard.
6. dig4 changed 0->9 mid-slot while sel=3, blank_lz=1: an goes 1111->0111 on the next edge, given cnt>=2.
